// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider with duty control and tick strobe
// Ports: clk/rst (sync, active-high) | en run enable, 0 parks outputs | load captures div_in/high_in (clamped)
//        clk_out divided level | tick last cycle of period | cnt_o phase | div_o active divisor | pending shadow waiting
module clk_div_prog #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 8,
  parameter int DEFAULT_HIGH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] div_o,
  output logic             pending
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_HIGH);
  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_cnt, r_div, r_high, r_sdiv, r_shigh;
  logic [WIDTH-1:0] w_cnt_n, w_div_n, w_high_n, w_sdiv_n, w_shigh_n, w_dc, w_hc;
  logic             r_pend, r_clk, r_tick;
  logic             w_pend_n, w_clk_n, w_tick_n, w_wrap, w_bound;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= DEF_D;
      r_high  <= DEF_H;
      r_sdiv  <= '0;
      r_shigh <= '0;
      r_pend  <= 1'b0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_div   <= w_div_n;
      r_high  <= w_high_n;
      r_sdiv  <= w_sdiv_n;
      r_shigh <= w_shigh_n;
      r_pend  <= w_pend_n;
      r_clk   <= w_clk_n;
      r_tick  <= w_tick_n;
    end
  end
  // A boundary is any edge spent in IDLE or a wrap edge; settings only change there,
  // so outputs for the next cycle are derived from the post-apply divisor/high count.
  always_comb begin
    w_dc      = (div_in < TWO) ? TWO : div_in;
    w_hc      = (high_in == '0) ? ONE : (high_in >= w_dc) ? w_dc - ONE : high_in;
    w_wrap    = (r_state == RUN) && en && (r_cnt == r_div - ONE);
    w_bound   = (r_state == IDLE) || w_wrap;
    w_div_n   = (w_bound && load) ? w_dc : (w_bound && r_pend) ? r_sdiv : r_div;
    w_high_n  = (w_bound && load) ? w_hc : (w_bound && r_pend) ? r_shigh : r_high;
    w_sdiv_n  = (!w_bound && load) ? w_dc : r_sdiv;
    w_shigh_n = (!w_bound && load) ? w_hc : r_shigh;
    w_pend_n  = !w_bound && (load || r_pend);
    w_state_n = en ? RUN : IDLE;
    w_cnt_n   = ((r_state == RUN) && en && !w_wrap) ? r_cnt + ONE : '0;
    w_clk_n   = en && (w_cnt_n < w_high_n);
    w_tick_n  = en && (w_cnt_n == w_div_n - ONE);
  end
  assign clk_out = r_clk;
  assign tick    = r_tick;
  assign cnt_o   = r_cnt;
  assign div_o   = r_div;
  assign pending = r_pend;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed and random checks of clk_div_prog against a behavioural model
module tb_clk_div_prog;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] div_in = '0;
  logic [7:0] high_in = '0;
  logic       clk_out, tick, pending;
  logic [7:0] cnt_o, div_o;
  int checks = 0;
  int errors = 0;
  bit m_run;
  int m_cnt, m_d, m_h, m_sd, m_sh;
  bit m_pend;
  logic [8:0] pat;

  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(8), .DEFAULT_HIGH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .div_in(div_in), .high_in(high_in),
    .clk_out(clk_out), .tick(tick), .cnt_o(cnt_o), .div_o(div_o), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit e, input bit l, input int d, input int h);
    int cd, ch;
    bit bnd;
    cd = (d < 2) ? 2 : d;
    ch = (h == 0) ? 1 : (h >= cd) ? cd - 1 : h;
    if (r) begin
      m_run = 0; m_cnt = 0; m_d = 8; m_h = 4; m_sd = 0; m_sh = 0; m_pend = 0;
      return;
    end
    bnd = !m_run || (e && m_cnt == m_d - 1);
    m_cnt = (e && m_run) ? (m_cnt + 1) % m_d : 0;
    if (bnd) begin
      if (l) begin m_d = cd; m_h = ch; end
      else if (m_pend) begin m_d = m_sd; m_h = m_sh; end
      m_pend = 0;
    end else if (l) begin
      m_sd = cd; m_sh = ch; m_pend = 1;
    end
    m_run = e;
  endtask

  task automatic step(input bit r, input bit e, input bit l, input int d, input int h);
    rst = r; en = e; load = l; div_in = 8'(d); high_in = 8'(h);
    @(posedge clk);
    model(r, e, l, d, h);
    #1;
    chk("cnt_o", 32'(cnt_o), 32'(m_cnt));
    chk("clk_out", 32'(clk_out), 32'(m_run && m_cnt < m_h));
    chk("tick", 32'(tick), 32'(m_run && m_cnt == m_d - 1));
    chk("div_o", 32'(div_o), 32'(m_d));
    chk("pending", 32'(pending), 32'(m_pend));
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic run_until(input int c);
    for (int i = 0; i < 300; i++) begin
      if (int'(cnt_o) == c) return;
      step(0, 1, 0, 0, 0);
    end
    chk("run_until_timeout", 32'(cnt_o), 32'(c));
  endtask

  initial begin
    repeat (3) step(1, 0, 0, 0, 0);
    chk("reset_div", 32'(div_o), 32'd8);
    step(0, 1, 0, 0, 0);
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      pat = {pat[7:0], clk_out};
      if (i < 7) step(0, 1, 0, 0, 0);
    end
    chk("default_pattern", 32'(pat[7:0]), 32'h0F0);
    run_until(2);
    step(0, 1, 1, 3, 1);
    chk("pending_after_load", 32'(pending), 32'd1);
    run_until(7);
    chk("pending_at_7", 32'(pending), 32'd1);
    step(0, 1, 0, 0, 0);
    chk("div_after_wrap", 32'(div_o), 32'd3);
    pat = '0;
    for (int i = 0; i < 9; i++) begin
      pat = {pat[7:0], clk_out};
      if (i < 8) step(0, 1, 0, 0, 0);
    end
    chk("div3_pattern", 32'(pat), 32'h124);
    step(0, 1, 1, 0, 5);
    repeat (6) step(0, 1, 0, 0, 0);
    chk("clamp_div2", 32'(div_o), 32'd2);
    step(0, 1, 1, 5, 0);
    repeat (12) step(0, 1, 0, 0, 0);
    chk("clamp_div5", 32'(div_o), 32'd5);
    step(0, 1, 1, 8, 4);
    repeat (8) step(0, 1, 0, 0, 0);
    run_until(7);
    step(0, 1, 1, 6, 3);
    chk("wrap_load_div", 32'(div_o), 32'd6);
    chk("wrap_load_pend", 32'(pending), 32'd0);
    run_until(1);
    step(0, 1, 1, 4, 2);
    step(0, 1, 1, 10, 7);
    run_until(0);
    chk("double_load_div", 32'(div_o), 32'd10);
    step(0, 1, 1, 8, 4);
    run_until(0);
    run_until(5);
    step(0, 0, 0, 0, 0);
    chk("stop_clk", 32'(clk_out), 32'd0);
    step(0, 0, 1, 4, 2);
    chk("idle_load_div", 32'(div_o), 32'd4);
    step(0, 1, 0, 0, 0);
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      pat = {pat[7:0], clk_out};
      if (i < 3) step(0, 1, 0, 0, 0);
    end
    chk("restart_pattern", 32'(pat[3:0]), 32'hC);
    run_until(1);
    step(0, 1, 1, 12, 6);
    run_until(3);
    chk("pend_before_rst", 32'(pending), 32'd1);
    step(1, 1, 1, 20, 3);
    chk("rst_div", 32'(div_o), 32'd8);
    repeat (20) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0,
           ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12),
           $urandom_range(0, 14));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
